// File: rtl/park_sensor_pkg.sv
// Shared types and default constants for the parking sensor array.
// Holds the alarm FSM state enum and the default parameter values.
package park_sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2
    } park_state_t;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_DETECT_TH  = 12;
    localparam int DEF_RELEASE_TH = 4;
    localparam int DEF_ALARM_MIN  = 2;
    localparam int DEF_BEEP_DIV   = 8;

endpackage

// File: rtl/park_sensor_array_channel.sv
// One obstacle channel: saturating up/down integrator with a hysteresis flag.
// Ports: clk, rst (async high), i_en (clear when low), i_obs (raw input),
//        o_flag (registered detected flag).
module park_channel #(
    parameter int CNT_W      = 4,
    parameter int DETECT_TH  = 12,
    parameter int RELEASE_TH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_obs,
    output logic o_flag
);

    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [CNT_W-1:0] DET_V = CNT_W'(DETECT_TH);
    localparam logic [CNT_W-1:0] REL_V = CNT_W'(RELEASE_TH);

    if (!((RELEASE_TH < DETECT_TH) && (DETECT_TH <= (2 ** CNT_W) - 1)))
    begin : g_bad_th
        $error("park_channel: thresholds out of range");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_flag;
    logic             w_flag_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_en) begin
            w_cnt_nxt = '0;
        end else if (i_obs) begin
            if (r_cnt != CMAX) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // Flag decision uses the value the counter is about to take.
    always_comb begin
        w_flag_nxt = r_flag;
        if (!i_en) begin
            w_flag_nxt = 1'b0;
        end else if (w_cnt_nxt >= DET_V) begin
            w_flag_nxt = 1'b1;
        end else if (w_cnt_nxt <= REL_V) begin
            w_flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_flag <= w_flag_nxt;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/park_sensor_array.sv
// Parking sensor array: N_CH integrating channels, popcount, alarm FSM, beeper.
// Ports: clk, reset (async high), park_enable, obstacle_detect[N_CH],
//        park_status[N_CH], det_count, alarm, beep.
module park_sensor_array
    import park_sensor_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DETECT_TH  = DEF_DETECT_TH,
    parameter int RELEASE_TH = DEF_RELEASE_TH,
    parameter int ALARM_MIN  = DEF_ALARM_MIN,
    parameter int BEEP_DIV   = DEF_BEEP_DIV
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       park_enable,
    input  logic [N_CH-1:0]            obstacle_detect,
    output logic [N_CH-1:0]            park_status,
    output logic [$clog2(N_CH+1)-1:0]  det_count,
    output logic                       alarm,
    output logic                       beep
);

    localparam int DC_W  = $clog2(N_CH + 1);
    localparam int DIV_W = $clog2(BEEP_DIV + 1);
    localparam logic [DC_W-1:0]  AMIN_V   = DC_W'(ALARM_MIN);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_DIV - 1);

    if (!((N_CH >= 1) && (N_CH <= 16) && (ALARM_MIN >= 1) &&
          (ALARM_MIN <= N_CH) && (BEEP_DIV >= 1)))
    begin : g_bad_cfg
        $error("park_sensor_array: parameter out of range");
    end

    logic [N_CH-1:0]  w_status;
    logic [DC_W-1:0]  w_det_count;
    park_state_t      r_state;
    park_state_t      w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic             r_phase;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        park_channel #(
            .CNT_W      (CNT_W),
            .DETECT_TH  (DETECT_TH),
            .RELEASE_TH (RELEASE_TH)
        ) u_ch (
            .clk    (clk),
            .rst    (reset),
            .i_en   (park_enable),
            .i_obs  (obstacle_detect[g]),
            .o_flag (w_status[g])
        );
    end

    always_comb begin
        w_det_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_det_count = w_det_count + DC_W'(w_status[i]);
        end
    end

    assign park_status = w_status;
    assign det_count   = w_det_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (!park_enable || w_det_count == '0) begin
            w_state_nxt = ST_IDLE;
        end else if (w_det_count < AMIN_V) begin
            w_state_nxt = ST_WARN;
        end else begin
            w_state_nxt = ST_ALARM;
        end
    end

    // Divider only runs while staying in WARN; any state change restarts
    // it so the beep always begins low on WARN entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (!park_enable || w_state_nxt != r_state ||
                     r_state != ST_WARN) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    always_comb begin
        alarm = 1'b0;
        beep  = 1'b0;
        unique case (r_state)
            ST_IDLE:  begin alarm = 1'b0; beep = 1'b0;    end
            ST_WARN:  begin alarm = 1'b0; beep = r_phase; end
            ST_ALARM: begin alarm = 1'b1; beep = 1'b1;    end
            default:  begin alarm = 1'b0; beep = 1'b0;    end
        endcase
    end

endmodule

// File: tb/tb_park_sensor_array.sv
// Self-checking bench for park_sensor_array with default parameters.
// Compares every cycle against a behavioural model of the sensor rules.
module tb_park_sensor_array;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int DT   = 12;
    localparam int RT   = 4;
    localparam int AMIN = 2;
    localparam int BD   = 8;
    localparam int DCW  = $clog2(N + 1);
    localparam int CMAX = (1 << CW) - 1;
    localparam int VW   = N + DCW + 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           park_enable;
    logic [N-1:0]   obstacle_detect;
    logic [N-1:0]   park_status;
    logic [DCW-1:0] det_count;
    logic           alarm;
    logic           beep;

    int total = 0;
    int bad   = 0;

    park_sensor_array #(
        .N_CH(N), .CNT_W(CW), .DETECT_TH(DT), .RELEASE_TH(RT),
        .ALARM_MIN(AMIN), .BEEP_DIV(BD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .park_enable     (park_enable),
        .obstacle_detect (obstacle_detect),
        .park_status     (park_status),
        .det_count       (det_count),
        .alarm           (alarm),
        .beep            (beep)
    );

    always #5 clk = ~clk;

    // Model: counters as integers, state as 0=idle 1=warn 2=alarm,
    // m_t = cycles spent in the current state.
    int           m_cnt [N];
    logic [N-1:0] m_flag;
    int           m_state;
    int           m_t;

    function automatic int pop(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic eb;
        logic ea;
        ea = (m_state == 2);
        if (m_state == 2)      eb = 1'b1;
        else if (m_state == 1) eb = ((m_t / BD) % 2) == 1;
        else                   eb = 1'b0;
        return {m_flag, DCW'(pop(m_flag)), ea, eb};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_flag  = '0;
        m_state = 0;
        m_t     = 0;
    endtask

    task automatic tick(input bit en, input logic [N-1:0] det);
        int op;
        int ns;
        park_enable     = en;
        obstacle_detect = det;
        @(posedge clk);
        op = pop(m_flag);
        if (!en) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (det[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                else        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                if (m_cnt[i] >= DT)      m_flag[i] = 1'b1;
                else if (m_cnt[i] <= RT) m_flag[i] = 1'b0;
            end
            ns = (op == 0) ? 0 : ((op < AMIN) ? 1 : 2);
            if (ns != m_state) m_t = 0;
            else               m_t++;
            m_state = ns;
        end
        #1;
    endtask

    function automatic logic [VW-1:0] got_vec();
        return {park_status, det_count, alarm, beep};
    endfunction

    task automatic test_reset();
        #2;
        total++;
        if (got_vec() !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h exp=0", got_vec());
        end
        @(posedge clk);
        #1;
        total++;
        if (got_vec() !== '0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=0", got_vec());
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_detect();
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, 4'b0001);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL detect k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            if (k == 11 || k == 12) begin
                total++;
                if (park_status !== ((k == 12) ? 4'b0001 : 4'b0000)) begin
                    bad++;
                    $display("FAIL detect_edge k=%0d status=%b", k, park_status);
                end
            end
        end
    endtask

    task automatic test_release();
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 4'b0000);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL release k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            if (k == 10 || k == 11) begin
                total++;
                if (park_status[0] !== (k == 10)) begin
                    bad++;
                    $display("FAIL release_edge k=%0d status=%b", k, park_status);
                end
            end
        end
    endtask

    task automatic test_alarm();
        for (int k = 1; k <= 24; k++) begin
            tick(1'b1, 4'b0101);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL alarm_up k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
        end
        total++;
        if (alarm !== 1'b1 || beep !== 1'b1 || det_count !== 3'd2) begin
            bad++;
            $display("FAIL alarm_on alarm=%b beep=%b dc=%0d exp 1 1 2",
                     alarm, beep, det_count);
        end
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, 4'b0001);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL alarm_down k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
        end
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL alarm_off alarm=%b exp=0", alarm);
        end
    endtask

    task automatic test_toggle();
        tick(1'b0, 4'b0000);
        for (int k = 1; k <= 30; k++) begin
            tick(1'b1, (k % 2) ? 4'b0010 : 4'b0000);
            total++;
            if (got_vec() !== exp_vec() || park_status[1] !== 1'b0) begin
                bad++;
                $display("FAIL toggle k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_enable_pulse();
        for (int k = 1; k <= 20; k++) tick(1'b1, 4'b1111);
        total++;
        if (park_status !== 4'b1111 || alarm !== 1'b1) begin
            bad++;
            $display("FAIL en_sat status=%b alarm=%b exp 1111 1", park_status, alarm);
        end
        tick(1'b0, 4'b1111);
        total++;
        if (got_vec() !== '0) begin
            bad++;
            $display("FAIL en_clear got=%h exp=0", got_vec());
        end
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1, 4'b1111);
            total++;
            if (got_vec() !== exp_vec() ||
                park_status !== ((k == 12) ? 4'b1111 : 4'b0000)) begin
                bad++;
                $display("FAIL en_reset k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 4'b0000);
        for (int k = 1; k <= 9; k++) tick(1'b1, 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (got_vec() !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=0", got_vec());
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick(1'b1, 4'b1000);
            total++;
            if (got_vec() !== exp_vec() ||
                park_status[3] !== (k >= 12)) begin
                bad++;
                $display("FAIL reset_resume k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] det = '0;
        bit           en;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) det[i] = ~det[i];
            end
            en = ($urandom_range(0, 199) != 0);
            tick(en, det);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        park_enable     = 1'b0;
        obstacle_detect = '0;
        model_clear();
        test_reset();
        test_detect();
        test_release();
        test_alarm();
        test_toggle();
        test_enable_pulse();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/park_sensor_array.md
PARK_SENSOR_ARRAY -- requirements
Module: park_sensor_array

Interface
REQ-001 Parameter N_CH, default 4: number of obstacle sensor channels, range 1..16.
REQ-002 Parameter CNT_W, default 4: width of each per-channel integrator counter.
REQ-003 Parameter DETECT_TH, default 12: counter value at which a channel flag sets.
REQ-004 Parameter RELEASE_TH, default 4: counter value at which a channel flag clears.
REQ-005 Parameter ALARM_MIN, default 2: number of flagged channels that forces ALARM.
REQ-006 Parameter BEEP_DIV, default 8: half-period of the WARN beep, in clk cycles, at least 1.
REQ-007 clk  in  1  single system clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 park_enable  in  1  global enable; low clears all state.
REQ-010 obstacle_detect  in  N_CH  raw per-channel obstacle inputs, already synchronous to clk.
REQ-011 park_status  out  N_CH  registered per-channel detected flags.
REQ-012 det_count  out  $clog2(N_CH+1)  population count of park_status.
REQ-013 alarm  out  1  high while the FSM is in ALARM.
REQ-014 beep  out  1  buzzer drive.

Function
REQ-015 With park_enable high and obstacle_detect[i]=1, counter i shall increment each cycle and saturate at 2^CNT_W-1.
REQ-016 With park_enable high and obstacle_detect[i]=0, counter i shall decrement each cycle and saturate at 0.
REQ-017 park_status[i] shall set on the edge where counter i's new value is >= DETECT_TH, clear on the edge where it is <= RELEASE_TH, and hold otherwise (hysteresis).
REQ-018 From counter 0 with a held obstacle, park_status[i] shall rise exactly DETECT_TH edges after the first asserted cycle.
REQ-019 det_count shall be combinational from the registered park_status, adding no latency.
REQ-020 The FSM shall have three states, IDLE, WARN and ALARM, and shall be registered one edge after det_count.
REQ-021 The FSM shall go to IDLE when det_count=0, to WARN when 1<=det_count<ALARM_MIN, and to ALARM when det_count>=ALARM_MIN.
REQ-022 Any-to-any FSM transitions shall be direct, with no intermediate states.
REQ-023 alarm shall be 1 only in ALARM.
REQ-024 beep shall be 0 in IDLE and 1 in ALARM.
REQ-025 In WARN, beep shall toggle every BEEP_DIV cycles, starting at 0 on WARN entry.
REQ-026 The beep divider shall restart on every state change.
REQ-027 park_enable low shall clear all counters, park_status, the divider, and the FSM (to IDLE) on the next edge, regardless of obstacle_detect.
REQ-028 Channels shall be independent; simultaneous set and clear on different channels in one cycle shall be reflected in det_count.
REQ-029 Elaboration shall fail unless RELEASE_TH < DETECT_TH <= 2^CNT_W-1 and 1 <= ALARM_MIN <= N_CH.

Reset
REQ-030 reset high shall immediately force all counters=0, park_status=0, det_count=0, FSM=IDLE, alarm=0, beep=0, and divider=0.
REQ-031 reset asserted mid-operation shall abort the operation with no residual state, and counting shall resume from 0 on the first edge after deassertion.

Structure
REQ-032 Package park_sensor_pkg shall hold the FSM state enum and the default parameter constants.
REQ-033 Sub-module park_channel shall implement one counter plus hysteresis flag, parameterised by CNT_W, DETECT_TH and RELEASE_TH, and shall be instantiated N_CH times via generate.
REQ-034 The popcount, FSM and beep divider shall reside in park_sensor_array.

Verification (default parameters)
REQ-035 Hold obstacle_detect=4'b0001 from reset release -> park_status=0001 after 12th edge, det_count=1, alarm=0, FSM WARN next edge, beep 0 for 8 cycles then toggles every 8.
REQ-036 Saturate ch0 (counter 15), then obstacle_detect=0 -> park_status[0] stays 1 for 10 edges, clears on 11th (counter=4), FSM IDLE next edge, beep=0.
REQ-037 Saturate ch0 and ch2 -> det_count=2, alarm=1 and beep=1 constant; drop ch2 below release -> WARN, alarm=0, beep restarts at 0.
REQ-038 Toggle obstacle_detect[1] each cycle from counter 0 -> counter oscillates 0/1, park_status[1] never sets.
REQ-039 Saturate all channels, pulse park_enable low one cycle -> all outputs 0 next edge; re-enable -> flags re-set 12 edges later.
REQ-040 Assert reset mid-count (ch3 counter=9) -> immediate all-zero outputs; after release ch3 needs a full 12 edges to flag.
